// File: rtl/lsu_bus_master.sv
// lsu_bus_master
// Purpose: single-outstanding load/store unit bus master. It accepts one core
// request in IDLE, performs one WRITE or READ access on a simple strobe bus,
// and finishes with a one-cycle oDone pulse. oFault accompanies oDone when the
// request is rejected.
//
// Ports:
//   iCLK, iRSTn           clock and asynchronous active-low reset
//   iReq, iWe, iFunct3    request, store/load select, RV32I width/sign code
//   iAddr, iWData         byte address and right-aligned store data
//   oBusy, oDone, oFault  status: busy in WRITE/READ, completion, rejection
//   oRData                extended load result (holds until the next load)
//   oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData, iReadData
//                         data-memory bus
//   oState                debug view of the FSM state (0 IDLE,1 WRITE,2 READ,3 DONE)
//
// Parameter READ_WAIT (0-7): extra cycles oReadEnable is held before sampling.
// Macro LSU_MISALIGN_CHECK_EN: when defined, misaligned H/W accesses fault;
// when undefined, H is forced to a halfword boundary and W to offset 0.
//
// Handshake: iReq is sampled only in IDLE. A request seen there is consumed on
// that edge; requests in WRITE/READ/DONE are dropped, not queued. oDone is a
// single-cycle pulse that the core must not stall.
module lsu_bus_master #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFault,
  output logic [31:0] oRData,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } lsuState;

  localparam logic [2:0] LAST_WAIT = READ_WAIT[2:0];

  lsuState     state;
  logic [2:0]  waitCnt;
  logic        captured;   // read word taken; one more cycle to extend it
  logic [2:0]  ldFunct3;
  logic [1:0]  ldOff;
  logic [31:0] rawWord;

  // Request decode, only meaningful in IDLE.
  logic        reqFault;
  logic [1:0]  reqOff;
  logic [3:0]  reqBe;
  logic [31:0] reqWData;

  always_comb begin
    reqFault = 1'b0;
    reqOff   = 2'b00;
    reqBe    = 4'b0000;
    reqWData = 32'h0;
    if (iWe)
      reqFault = !(iFunct3 == 3'b000 || iFunct3 == 3'b001 || iFunct3 == 3'b010);
    else
      reqFault = (iFunct3 == 3'b011 || iFunct3 == 3'b110 || iFunct3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
    if (iFunct3[1:0] == 2'b01 && iAddr[0])
      reqFault = 1'b1;
    if (iFunct3[1:0] == 2'b10 && iAddr[1:0] != 2'b00)
      reqFault = 1'b1;
`endif
    // Halfword offset ignores addr[0]; with the check enabled that bit is
    // already known to be zero for legal requests, so one path serves both.
    case (iFunct3[1:0])
      2'b00: begin
        reqOff   = iAddr[1:0];
        reqBe    = 4'b0001 << reqOff;
        reqWData = {4{iWData[7:0]}};
      end
      2'b01: begin
        reqOff   = {iAddr[1], 1'b0};
        reqBe    = 4'b0011 << reqOff;
        reqWData = {2{iWData[15:0]}};
      end
      default: begin
        reqOff   = 2'b00;
        reqBe    = 4'b1111;
        reqWData = iWData;
      end
    endcase
  end

  function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   r = f3[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state        <= IDLE;
      waitCnt      <= 3'd0;
      captured     <= 1'b0;
      ldFunct3     <= 3'd0;
      ldOff        <= 2'd0;
      rawWord      <= 32'h0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oFault       <= 1'b0;
      oRData       <= 32'h0;
      oReadEnable  <= 1'b0;
      oWriteEnable <= 1'b0;
      oByteEnable  <= 4'h0;
      oAddress     <= 32'h0;
      oWriteData   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          oDone  <= 1'b0;
          oFault <= 1'b0;
          if (iReq) begin
            ldFunct3 <= iFunct3;
            ldOff    <= reqOff;
            waitCnt  <= 3'd0;
            captured <= 1'b0;
            if (reqFault) begin
              state  <= DONE;
              oDone  <= 1'b1;
              oFault <= 1'b1;
            end else begin
              oBusy       <= 1'b1;
              oAddress    <= {iAddr[31:2], 2'b00};
              oByteEnable <= reqBe;
              if (iWe) begin
                state        <= WRITE;
                oWriteEnable <= 1'b1;
                oWriteData   <= reqWData;
              end else begin
                state       <= READ;
                oReadEnable <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          state        <= DONE;
          oWriteEnable <= 1'b0;
          oBusy        <= 1'b0;
          oAddress     <= 32'h0;
          oByteEnable  <= 4'h0;
          oWriteData   <= 32'h0;
          oDone        <= 1'b1;
        end
        READ: begin
          if (!captured) begin
            if (waitCnt == LAST_WAIT) begin
              rawWord     <= iReadData;
              captured    <= 1'b1;
              oReadEnable <= 1'b0;
            end else begin
              waitCnt <= waitCnt + 3'd1;
            end
          end else begin
            // Extension cycle: the sampled word is aligned and extended here.
            state       <= DONE;
            oRData      <= extendLoad(rawWord, ldFunct3, ldOff);
            oBusy       <= 1'b0;
            oAddress    <= 32'h0;
            oByteEnable <= 4'h0;
            oDone       <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          waitCnt  <= 3'd0;
          captured <= 1'b0;
          oDone    <= 1'b0;
          oFault   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master
// Directed bench for lsu_bus_master with READ_WAIT = 1. A table of access
// records gives each request and its hand-computed bus image, strobe counts,
// latency and load result; hand-written sequences cover reset, a held iReq
// and reset in the middle of a read.
module tb_lsu_bus_master;

  logic        iCLK;
  logic        iRSTn;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy;
  logic        oDone;
  logic        oFault;
  logic [31:0] oRData;
  logic        oReadEnable;
  logic        oWriteEnable;
  logic [3:0]  oByteEnable;
  logic [31:0] oAddress;
  logic [31:0] oWriteData;
  logic [31:0] iReadData;
  logic [1:0]  oState;

  int checks = 0;
  int failures = 0;

  lsu_bus_master #(.READ_WAIT(1)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iReq(iReq), .iWe(iWe), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWData(iWData), .oBusy(oBusy), .oDone(oDone),
    .oFault(oFault), .oRData(oRData), .oReadEnable(oReadEnable),
    .oWriteEnable(oWriteEnable), .oByteEnable(oByteEnable),
    .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData),
    .oState(oState)
  );

  // Clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdIn;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    int          nWr;
    int          nRd;
    int          lat;
    logic [31:0] rdExp;
  } accVec;

  accVec vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic runAccess(input accVec v, input int idx);
    int lat = 0, nWr = 0, nRd = 0, nBusy = 0, busBad = 0, both = 0, strayFault = 0;
    logic faultSeen = 1'b0;
    logic [67:0] doneBus = '0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge iCLK);
    iReq = 1'b1; iWe = v.we; iFunct3 = v.f3; iAddr = v.addr;
    iWData = v.wdata; iReadData = v.rdIn;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge iCLK);
      iReq = 1'b0;
      if (oWriteEnable && oReadEnable) both++;
      if (oWriteEnable) nWr++;
      if (oReadEnable) nRd++;
      if (oBusy) nBusy++;
      if (oWriteEnable || oReadEnable)
        if ({oAddress, oByteEnable, oWriteData} !== {v.busAddr, v.be, v.busWData}) busBad++;
      if (oFault && !oDone) strayFault++;
      if (oDone) begin
        lat = cyc;
        faultSeen = oFault;
        doneBus = {oAddress, oByteEnable, oWriteData};
      end
    end
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_fault"}, {31'b0, faultSeen}, {31'b0, v.fault});
    check({tag, "_writes"}, nWr, v.nWr);
    check({tag, "_reads"}, nRd, v.nRd);
    check({tag, "_busy"}, nBusy, v.fault ? 0 : v.lat - 1);
    check({tag, "_busimage"}, busBad, 0);
    check({tag, "_bothstrobes"}, both, 0);
    check({tag, "_strayfault"}, strayFault, 0);
    check({tag, "_donebus"}, {31'b0, |doneBus}, 32'h0);
    check({tag, "_rdata"}, oRData, v.rdExp);
    @(negedge iCLK);
    check({tag, "_donepulse"}, {31'b0, oDone}, 32'h0);
  endtask

  // Stimulus and scoreboard
  initial begin
    int nRd, nDone;
    accVec v;
    iRSTn = 1'b0; iReq = 1'b0; iWe = 1'b0; iFunct3 = 3'b000;
    iAddr = 32'h0; iWData = 32'h0; iReadData = 32'h0;

    vecs[0]  = '{1'b1, 3'b000, 32'h10010003, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'h10010000, 32'hA5A5A5A5, 1, 0, 2, 32'h0};
    vecs[1]  = '{1'b1, 3'b001, 32'h10010002, 32'h1234BEEF, 32'h0, 1'b0, 4'b1100, 32'h10010000, 32'hBEEFBEEF, 1, 0, 2, 32'h0};
    vecs[2]  = '{1'b1, 3'b010, 32'h10010004, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'h10010004, 32'hDEADBEEF, 1, 0, 2, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 32'h10010002, 32'h0, 32'h00807F00, 1'b0, 4'b0100, 32'h10010000, 32'h0, 0, 2, 4, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 3'b100, 32'h10010002, 32'h0, 32'h00807F00, 1'b0, 4'b0100, 32'h10010000, 32'h0, 0, 2, 4, 32'h00000080};
    vecs[5]  = '{1'b0, 3'b001, 32'h10010000, 32'h0, 32'h12348001, 1'b0, 4'b0011, 32'h10010000, 32'h0, 0, 2, 4, 32'hFFFF8001};
    vecs[6]  = '{1'b0, 3'b101, 32'h10010002, 32'h0, 32'h87650000, 1'b0, 4'b1100, 32'h10010000, 32'h0, 0, 2, 4, 32'h00008765};
    vecs[7]  = '{1'b0, 3'b010, 32'h10010008, 32'h0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h10010008, 32'h0, 0, 2, 4, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 3'b011, 32'h10010000, 32'hFFFFFFFF, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 3'b111, 32'h10010004, 32'h0, 32'h12345678, 1'b1, 4'b0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 3'b100, 32'h10010001, 32'h00000055, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[11] = '{1'b0, 3'b001, 32'h10010001, 32'h0, 32'hAAAAF234, 1'b1, 4'b0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D};
    vecs[12] = '{1'b1, 3'b010, 32'h10010002, 32'h11223344, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 0, 0, 1, 32'hCAFEF00D};
`else
    vecs[11] = '{1'b0, 3'b001, 32'h10010001, 32'h0, 32'hAAAAF234, 1'b0, 4'b0011, 32'h10010000, 32'h0, 0, 2, 4, 32'hFFFFF234};
    vecs[12] = '{1'b1, 3'b010, 32'h10010002, 32'h11223344, 32'h0, 1'b0, 4'b1111, 32'h10010000, 32'h11223344, 1, 0, 2, 32'hFFFFF234};
`endif

    // Reset state
    repeat (2) @(negedge iCLK);
    check("reset_status", {29'b0, oBusy, oDone, oFault}, 32'h0);
    check("reset_strobes", {30'b0, oReadEnable, oWriteEnable}, 32'h0);
    check("reset_bus", {oAddress[31:4], oAddress[3:0] | oByteEnable}, 32'h0);
    check("reset_wdata", oWriteData, 32'h0);
    check("reset_rdata", oRData, 32'h0);
    check("reset_state", {30'b0, oState}, 32'h0);
    iRSTn = 1'b1;

    // Table-driven accesses
    for (int i = 0; i < 13; i++) runAccess(vecs[i], i);

    // iReq held high across a load: exactly one access
    @(negedge iCLK);
    iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h10010000;
    iReadData = 32'h0BADF00D;
    nRd = 0; nDone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge iCLK);
      if (oReadEnable) nRd++;
      if (oDone) begin nDone++; iReq = 1'b0; end
    end
    iReq = 1'b0;
    check("held_req_reads", nRd, 2);
    check("held_req_dones", nDone, 1);
    check("held_req_rdata", oRData, 32'h0BADF00D);

    // Reset in the second READ cycle
    @(negedge iCLK);
    iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h10010000;
    iReadData = 32'hFFFF0000;
    @(negedge iCLK);
    iReq = 1'b0;
    @(negedge iCLK);
    check("midread_strobe_before", {31'b0, oReadEnable}, 32'h1);
    iRSTn = 1'b0;
    #1;
    check("midread_strobes", {30'b0, oReadEnable, oWriteEnable}, 32'h0);
    check("midread_busy", {31'b0, oBusy}, 32'h0);
    check("midread_rdata", oRData, 32'h0);
    check("midread_bus", oAddress | {28'b0, oByteEnable}, 32'h0);
    nDone = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge iCLK);
      if (oDone) nDone++;
    end
    check("midread_nodone", nDone, 0);
    iRSTn = 1'b1;
    v = '{1'b0, 3'b010, 32'h10010000, 32'h0, 32'h12345678, 1'b0, 4'b1111, 32'h10010000, 32'h0, 0, 2, 4, 32'h12345678};
    runAccess(v, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run must always end with the summary line.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
